conv1_ifmap_streamer: RTL

//   Producer side of the ConvLayer1 input interface. Collects an upstream 8-bit pixel

---
 rtl/conv1_ifmap_streamer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/conv1_ifmap_streamer.sv
// Buffers one raster-order pixel frame, then replays it one full row per cycle
// toward the ConvLayer1 input, followed by a drain gap before accepting the next frame.
module conv1_ifmap_streamer #(
  parameter int PIX_W      = 8,
  parameter int COLS       = 26,
  parameter int ROWS       = 26,
  parameter int GAP_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_vald,
  output logic                  pix_rdy,
  output logic [COLS*PIX_W-1:0] Ifmap_shift_out,
  output logic                  din_vald,
  output logic                  en,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int ROW_W = COLS * PIX_W;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = $clog2(ROWS + 1);
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(ROWS);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [ROW_W-1:0]  out_q, out_d;
  logic              en_q, en_d;
  logic              dv_q, dv_d;
  logic              xfer;
  logic              wr_en;
  int                wr_lsb;

  logic [ROW_W-1:0]  mem_q [ROWS];

  // Handshake: a pixel moves on a rising edge where pix_vald and pix_rdy are both
  // high; pix_rdy never depends on pix_vald, and a held pix_vald simply waits.
  assign pix_rdy         = (state_q == S_FILL) & rst_n;
  assign xfer            = pix_vald & pix_rdy;
  assign Ifmap_shift_out = out_q;
  assign din_vald        = dv_q;
  assign en              = en_q;
  assign busy            = (state_q != S_FILL);
  assign dbg_state       = state_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    out_d   = '0;
    en_d    = 1'b0;
    dv_d    = 1'b0;
    wr_en   = 1'b0;
    wr_lsb  = (COLS - 1 - int'(col_q)) * PIX_W;
    case (state_q)
      S_FILL: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              // Row 0 is already complete, so it goes out on the same edge that
              // stores the final pixel; row_q then points at the next row to load.
              state_d = S_STREAM;
              row_d   = RW'(1);
              out_d   = mem_q[0];
              en_d    = 1'b1;
              dv_d    = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_STREAM: begin
        if (row_q == ROW_END) begin
          row_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? S_FILL : S_GAP;
        end else begin
          out_d = mem_q[row_q];
          en_d  = 1'b1;
          row_d = row_q + RW'(1);
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = S_FILL;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = S_FILL;
        col_d   = '0;
        row_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      en_q    <= en_d;
      dv_q    <= dv_d;
    end
  end

  // Frame storage needs no reset; wr_en is already gated by rst_n through pix_rdy.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[row_q][wr_lsb +: PIX_W] <= pix_in;
    end
  end

endmodule
